// File: rtl/pwm_config_sequencer_if.sv
// rtl/pwm_config_sequencer_if.sv - command and AXI4-Lite write-channel bundle for the PWM config sequencer
//
// Purpose: groups the command request, completion pulses and the AXI4-Lite
// write channels (AW/W/B) used by pwm_config_sequencer.
// Signal suffixes are relative to the sequencer: _i = into it, _o = out of it.
// Ports (interface members):
//   cmd_valid_i/cmd_ready_o         command handshake
//   cmd_ch_i, cmd_mode_i            target channel, final MODE
//   cmd_period_i/th1_i/th2_i/step_i channel configuration values
//   done_o, err_o                   one-cycle completion pulses
//   m_axi_aw*/m_axi_w*/m_axi_b*     AXI4-Lite write address/data/response
// Modports: master = sequencer side, slave = PWM peripheral / bench side.
interface pwm_config_sequencer_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_ch_i;
  logic [1:0]  cmd_mode_i;
  logic [31:0] cmd_period_i;
  logic [31:0] cmd_th1_i;
  logic [31:0] cmd_th2_i;
  logic [11:0] cmd_step_i;
  logic        done_o;
  logic        err_o;
  logic [31:0] m_axi_awaddr_o;
  logic        m_axi_awvalid_o;
  logic        m_axi_awready_i;
  logic [31:0] m_axi_wdata_o;
  logic [3:0]  m_axi_wstrb_o;
  logic        m_axi_wvalid_o;
  logic        m_axi_wready_i;
  logic        m_axi_bvalid_i;
  logic        m_axi_bready_o;
  logic        m_axi_bresp_i;

  modport master (
    input  cmd_valid_i, cmd_ch_i, cmd_mode_i, cmd_period_i, cmd_th1_i, cmd_th2_i, cmd_step_i,
    input  m_axi_awready_i, m_axi_wready_i, m_axi_bvalid_i, m_axi_bresp_i,
    output cmd_ready_o, done_o, err_o,
    output m_axi_awaddr_o, m_axi_awvalid_o, m_axi_wdata_o, m_axi_wstrb_o, m_axi_wvalid_o,
    output m_axi_bready_o
  );

  modport slave (
    output cmd_valid_i, cmd_ch_i, cmd_mode_i, cmd_period_i, cmd_th1_i, cmd_th2_i, cmd_step_i,
    output m_axi_awready_i, m_axi_wready_i, m_axi_bvalid_i, m_axi_bresp_i,
    input  cmd_ready_o, done_o, err_o,
    input  m_axi_awaddr_o, m_axi_awvalid_o, m_axi_wdata_o, m_axi_wstrb_o, m_axi_wvalid_o,
    input  m_axi_bready_o
  );
endinterface

// File: rtl/pwm_config_sequencer.sv
// rtl/pwm_config_sequencer.sv - AXI4-Lite write master programming one PWM channel per command
//
// Purpose: turns one command into six AXI4-Lite writes: MODE=0, PERIOD, THRESHOLD1,
// THRESHOLD2, STEP, then MODE=commanded, so the channel never runs half-configured.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    pwm_config_sequencer_if.master (command, done/err pulses, AXI4-Lite AW/W/B)
module pwm_config_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter logic [31:0] CH_STRIDE = 32'h0000_0100,
  parameter logic [15:0] TIMEOUT   = 16'd255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  pwm_config_sequencer_if.master        bus
);

  typedef enum logic [1:0] {IDLE, WR, RESP} state_e;

  // Abort fires on the edge at which the per-write counter would reach TIMEOUT.
  localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d, k_nxt;
  logic [15:0] cnt_q, cnt_d;
  logic        ch_q, ch_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] period_q, period_d, th1_q, th1_d, th2_q, th2_d;
  logic [11:0] step_q, step_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic        done_q, done_d, err_q, err_d;
  logic        aw_ok, w_ok;

  function automatic logic [31:0] addr_of(input logic ch, input logic [2:0] k);
    logic [31:0] off;
    case (k)
      3'd1:    off = 32'h04;
      3'd2:    off = 32'h08;
      3'd3:    off = 32'h0C;
      3'd4:    off = 32'h10;
      default: off = 32'h00;  // k0 and k5 both target MODE
    endcase
    return BASE_ADDR + (ch ? CH_STRIDE : 32'h0) + off;
  endfunction

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    k_nxt     = k_q + 3'd1;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    mode_d    = mode_q;
    period_d  = period_q;
    th1_d     = th1_q;
    th2_d     = th2_q;
    step_d    = step_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    aw_ok     = 1'b0;
    w_ok      = 1'b0;

    case (state_q)
      IDLE: begin
        // cmd_ready_o is high throughout IDLE, so valid alone means acceptance.
        if (bus.cmd_valid_i) begin
          ch_d      = bus.cmd_ch_i;
          mode_d    = bus.cmd_mode_i;
          period_d  = bus.cmd_period_i;
          th1_d     = bus.cmd_th1_i;
          th2_d     = bus.cmd_th2_i;
          step_d    = bus.cmd_step_i;
          k_d       = 3'd0;
          cnt_d     = 16'd0;
          awaddr_d  = addr_of(bus.cmd_ch_i, 3'd0);
          wdata_d   = 32'd0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR;
        end
      end

      WR: begin
        cnt_d = cnt_q + 16'd1;
        // A channel is finished if it already handshook or handshakes this edge.
        aw_ok = !awvalid_q || bus.m_axi_awready_i;
        w_ok  = !wvalid_q  || bus.m_axi_wready_i;
        if (awvalid_q && bus.m_axi_awready_i) awvalid_d = 1'b0;
        if (wvalid_q  && bus.m_axi_wready_i)  wvalid_d  = 1'b0;
        if (cnt_q == TO_LAST) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else if (aw_ok && w_ok) begin
          state_d = RESP;
        end
      end

      RESP: begin
        cnt_d = cnt_q + 16'd1;
        // A response accepted on the last allowed edge still counts.
        if (bus.m_axi_bvalid_i) begin
          if (bus.m_axi_bresp_i) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (k_q == 3'd5) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            k_d       = k_nxt;
            cnt_d     = 16'd0;
            awaddr_d  = addr_of(ch_q, k_nxt);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
            case (k_nxt)
              3'd1:    wdata_d = period_q;
              3'd2:    wdata_d = th1_q;
              3'd3:    wdata_d = th2_q;
              3'd4:    wdata_d = {20'b0, step_q};
              default: wdata_d = {30'b0, mode_q};
            endcase
          end
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      k_q       <= 3'd0;
      cnt_q     <= 16'd0;
      ch_q      <= 1'b0;
      mode_q    <= 2'd0;
      period_q  <= 32'd0;
      th1_q     <= 32'd0;
      th2_q     <= 32'd0;
      step_q    <= 12'd0;
      awaddr_q  <= 32'd0;
      wdata_q   <= 32'd0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      th1_q     <= th1_d;
      th2_q     <= th2_d;
      step_q    <= step_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.cmd_ready_o     = (state_q == IDLE);
  assign bus.done_o          = done_q;
  assign bus.err_o           = err_q;
  assign bus.m_axi_awaddr_o  = awaddr_q;
  assign bus.m_axi_awvalid_o = awvalid_q;
  assign bus.m_axi_wdata_o   = wdata_q;
  assign bus.m_axi_wstrb_o   = 4'hF;
  assign bus.m_axi_wvalid_o  = wvalid_q;
  assign bus.m_axi_bready_o  = (state_q == RESP);

endmodule

// File: tb/tb_pwm_config_sequencer.sv
// tb/tb_pwm_config_sequencer.sv - scoreboard testbench for pwm_config_sequencer
module tb_pwm_config_sequencer;
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  pwm_config_sequencer_if bus();

  pwm_config_sequencer #(
    .BASE_ADDR(32'h2000_0000),
    .CH_STRIDE(32'h0000_0100),
    .TIMEOUT  (16'd8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .bus  (bus)
  );

  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  typedef struct {logic is_err; int lat;} end_t;

  wr_t         exp_wr_q[$];
  end_t        exp_end_q[$];
  logic [31:0] got_aw_q[$];
  logic [31:0] got_w_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int wcount = 0;
  int aw_delay = 0;
  int err_k = -1;
  int hang_k = -1;
  int aw_wait = 0;

  logic        prev_aw_hs, prev_w_hs, prev_awv, prev_wv, aw_hs, w_hs;
  logic [31:0] prev_awaddr, prev_wdata, a_got, d_got;
  wr_t         e_wr;
  end_t        e_end;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Slave: optional AWREADY delay, immediate WREADY, B in the first RESP cycle.
  initial begin
    bus.m_axi_awready_i = 1'b0;
    bus.m_axi_wready_i  = 1'b0;
    bus.m_axi_bvalid_i  = 1'b0;
    bus.m_axi_bresp_i   = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.m_axi_awvalid_o) begin
        if (aw_wait >= aw_delay) bus.m_axi_awready_i = 1'b1;
        else begin
          bus.m_axi_awready_i = 1'b0;
          aw_wait++;
        end
      end else begin
        bus.m_axi_awready_i = 1'b0;
        aw_wait = 0;
      end
      bus.m_axi_wready_i = bus.m_axi_wvalid_o;
      if (bus.m_axi_bready_o && (wcount - 1) != hang_k) begin
        bus.m_axi_bvalid_i = 1'b1;
        bus.m_axi_bresp_i  = ((wcount - 1) == err_k);
      end else begin
        bus.m_axi_bvalid_i = 1'b0;
        bus.m_axi_bresp_i  = 1'b0;
      end
    end
  end

  // Monitor: samples between edges, pairs AW/W handshakes and pops expectations.
  initial begin
    prev_aw_hs = 1'b0; prev_w_hs = 1'b0; prev_awv = 1'b0; prev_wv = 1'b0;
    prev_awaddr = 32'd0; prev_wdata = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_i) begin
        got_aw_q.delete();
        got_w_q.delete();
        prev_aw_hs = 1'b0; prev_w_hs = 1'b0; prev_awv = 1'b0; prev_wv = 1'b0;
      end else begin
        aw_hs = bus.m_axi_awvalid_o && bus.m_axi_awready_i;
        w_hs  = bus.m_axi_wvalid_o && bus.m_axi_wready_i;
        if (prev_aw_hs) chk("awvalid_drop", {31'd0, bus.m_axi_awvalid_o}, 32'd0);
        if (prev_w_hs)  chk("wvalid_drop", {31'd0, bus.m_axi_wvalid_o}, 32'd0);
        if (prev_awv && !prev_aw_hs && bus.m_axi_awvalid_o)
          chk("awaddr_stable", bus.m_axi_awaddr_o, prev_awaddr);
        if (prev_wv && !prev_w_hs && bus.m_axi_wvalid_o)
          chk("wdata_stable", bus.m_axi_wdata_o, prev_wdata);
        if (bus.cmd_valid_i && bus.cmd_ready_o) accept_cyc = cyc + 1;
        if (aw_hs) got_aw_q.push_back(bus.m_axi_awaddr_o);
        if (w_hs) begin
          got_w_q.push_back(bus.m_axi_wdata_o);
          chk("wstrb", {28'd0, bus.m_axi_wstrb_o}, 32'h0000_000F);
          wcount++;
        end
        while (got_aw_q.size() != 0 && got_w_q.size() != 0) begin
          a_got = got_aw_q.pop_front();
          d_got = got_w_q.pop_front();
          if (exp_wr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got addr %h data %h, none expected", a_got, d_got);
          end else begin
            e_wr = exp_wr_q.pop_front();
            chk("awaddr", a_got, e_wr.addr);
            chk("wdata", d_got, e_wr.data);
          end
        end
        if (bus.done_o || bus.err_o) begin
          chk("done_err_exclusive", {31'd0, bus.done_o && bus.err_o}, 32'd0);
          chk("cmd_ready_at_end", {31'd0, bus.cmd_ready_o}, 32'd1);
          chk("valids_low_at_end",
              {29'd0, bus.m_axi_awvalid_o, bus.m_axi_wvalid_o, bus.m_axi_bready_o}, 32'd0);
          if (exp_end_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_end: got done=%0b err=%0b, none expected", bus.done_o, bus.err_o);
          end else begin
            e_end = exp_end_q.pop_front();
            chk("end_is_err", {31'd0, bus.err_o}, {31'd0, e_end.is_err});
            chk("end_latency", cyc - accept_cyc, e_end.lat);
            chk("writes_outstanding", exp_wr_q.size(), 32'd0);
          end
        end
        prev_aw_hs  = aw_hs;
        prev_w_hs   = w_hs;
        prev_awv    = bus.m_axi_awvalid_o;
        prev_wv     = bus.m_axi_wvalid_o;
        prev_awaddr = bus.m_axi_awaddr_o;
        prev_wdata  = bus.m_axi_wdata_o;
      end
    end
  end

  // Expected write table for one command; lat < 0 means no done/err is expected.
  task automatic push_seq(input logic ch, input logic [1:0] mode, input logic [31:0] p,
                          input logic [31:0] t1, input logic [31:0] t2, input logic [11:0] st,
                          input int nwr, input logic is_err, input int lat);
    wr_t tbl[6];
    logic [31:0] base;
    end_t e;
    base = ch ? 32'h2000_0100 : 32'h2000_0000;
    tbl[0] = '{base,          32'd0};
    tbl[1] = '{base + 32'h04, p};
    tbl[2] = '{base + 32'h08, t1};
    tbl[3] = '{base + 32'h0C, t2};
    tbl[4] = '{base + 32'h10, {20'd0, st}};
    tbl[5] = '{base,          {30'd0, mode}};
    for (int i = 0; i < nwr; i++) exp_wr_q.push_back(tbl[i]);
    if (lat >= 0) begin
      e.is_err = is_err;
      e.lat    = lat;
      exp_end_q.push_back(e);
    end
  endtask

  task automatic issue(input logic ch, input logic [1:0] mode, input logic [31:0] p,
                       input logic [31:0] t1, input logic [31:0] t2, input logic [11:0] st);
    int n;
    @(negedge clk);
    wcount = 0;
    bus.cmd_ch_i = ch; bus.cmd_mode_i = mode; bus.cmd_period_i = p;
    bus.cmd_th1_i = t1; bus.cmd_th2_i = t2; bus.cmd_step_i = st;
    bus.cmd_valid_i = 1'b1;
    n = 0;
    while (!bus.cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL cmd_accept: cmd_ready_o stayed 0 for %0d cycles", n);
    end
    @(negedge clk);
    // Scramble inputs after acceptance; the latched command must be used.
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_ch_i     = 1'($urandom_range(0, 1));
    bus.cmd_mode_i   = 2'($urandom);
    bus.cmd_period_i = $urandom;
    bus.cmd_th1_i    = $urandom;
    bus.cmd_th2_i    = $urandom;
    bus.cmd_step_i   = 12'($urandom);
  endtask

  task automatic wait_end(input int max);
    int n;
    n = 0;
    while (exp_end_q.size() != 0 && n < max) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (exp_end_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL end_timeout: no done/err within %0d cycles", max);
      exp_end_q.delete();
      exp_wr_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready_o}, 32'd1);
    chk({tag, "_valids"}, {29'd0, bus.m_axi_awvalid_o, bus.m_axi_wvalid_o, bus.m_axi_bready_o}, 32'd0);
    chk({tag, "_awaddr"}, bus.m_axi_awaddr_o, 32'd0);
    chk({tag, "_wdata"}, bus.m_axi_wdata_o, 32'd0);
    chk({tag, "_done_err"}, {30'd0, bus.done_o, bus.err_o}, 32'd0);
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    bus.cmd_valid_i = 1'b0; bus.cmd_ch_i = 1'b0; bus.cmd_mode_i = 2'd0;
    bus.cmd_period_i = 32'd0; bus.cmd_th1_i = 32'd0; bus.cmd_th2_i = 32'd0; bus.cmd_step_i = 12'd0;
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_i = 1'b0;

    // Ch0 nominal: 2 cycles per write, done at T+12.
    push_seq(1'b0, 2'd2, 32'd1000, 32'd250, 32'd750, 12'd5, 6, 1'b0, 12);
    issue(1'b0, 2'd2, 32'd1000, 32'd250, 32'd750, 12'd5);
    wait_end(100);

    // Ch1, same command.
    push_seq(1'b1, 2'd2, 32'd1000, 32'd250, 32'd750, 12'd5, 6, 1'b0, 12);
    issue(1'b1, 2'd2, 32'd1000, 32'd250, 32'd750, 12'd5);
    wait_end(100);

    // AWREADY 3 cycles late on every write: 5 cycles per write.
    aw_delay = 3;
    push_seq(1'b0, 2'd1, 32'h0001_2345, 32'h0000_0ABC, 32'h0000_F00D, 12'hFFF, 6, 1'b0, 30);
    issue(1'b0, 2'd1, 32'h0001_2345, 32'h0000_0ABC, 32'h0000_F00D, 12'hFFF);
    wait_end(100);
    aw_delay = 0;

    // SLVERR on k2: three writes, err at T+6.
    err_k = 2;
    push_seq(1'b1, 2'd3, 32'd77, 32'd11, 32'd66, 12'd9, 3, 1'b1, 6);
    issue(1'b1, 2'd3, 32'd77, 32'd11, 32'd66, 12'd9);
    wait_end(100);
    repeat (20) @(negedge clk);
    err_k = -1;

    // No B on k1: k1 WR entry at T+2, timeout err 8 cycles later.
    hang_k = 1;
    push_seq(1'b0, 2'd1, 32'd500, 32'd100, 32'd400, 12'd3, 2, 1'b1, 10);
    issue(1'b0, 2'd1, 32'd500, 32'd100, 32'd400, 12'd3);
    wait_end(100);
    hang_k = -1;
    push_seq(1'b0, 2'd2, 32'd600, 32'd200, 32'd300, 12'd7, 6, 1'b0, 12);
    issue(1'b0, 2'd2, 32'd600, 32'd200, 32'd300, 12'd7);
    wait_end(100);

    // Reset pulse during k3 RESP.
    push_seq(1'b1, 2'd1, 32'd900, 32'd90, 32'd450, 12'd1, 4, 1'b0, -1);
    issue(1'b1, 2'd1, 32'd900, 32'd90, 32'd450, 12'd1);
    n = 0;
    while (!(wcount == 4 && bus.m_axi_bready_o) && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL reach_k3_resp: not reached within %0d cycles", n);
    end
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    chk("midreset_writes_outstanding", exp_wr_q.size(), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    exp_wr_q.delete();
    repeat (5) @(negedge clk);
    push_seq(1'b1, 2'd3, 32'd123, 32'd45, 32'd67, 12'd89, 6, 1'b0, 12);
    issue(1'b1, 2'd3, 32'd123, 32'd45, 32'd67, 12'd89);
    wait_end(100);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
